// File: rtl/rr_request_agent_if.sv
// rtl/rr_request_agent_if.sv - job/arbiter/bus signal bundle for rr_request_agent
//
// Purpose: groups the job inputs, arbiter handshake and shared-bus outputs of
// the round-robin request agent.
// Signals:
//   job_valid[3:0] - per-channel job pulses (source -> agent)
//   grant[3:0]     - one-hot grant (arbiter -> agent)
//   req[3:0]       - per-channel request (agent -> arbiter)
//   bus_valid      - transfer beat active
//   bus_ch[1:0]    - owning channel during a beat
//   bus_beat[3:0]  - beat number inside the transfer
//   job_done[3:0]  - completion pulse on the owner channel
//   grant_err      - illegal-grant pulse
//   overflow[3:0]  - sticky dropped-job flags
// Modports: master = agent side, slave = sources/arbiter/bus side.
interface rr_request_agent_if;
    logic [3:0] job_valid;
    logic [3:0] grant;
    logic [3:0] req;
    logic       bus_valid;
    logic [1:0] bus_ch;
    logic [3:0] bus_beat;
    logic [3:0] job_done;
    logic       grant_err;
    logic [3:0] overflow;

    modport master (
        input  job_valid, grant,
        output req, bus_valid, bus_ch, bus_beat, job_done, grant_err, overflow
    );

    modport slave (
        output job_valid, grant,
        input  req, bus_valid, bus_ch, bus_beat, job_done, grant_err, overflow
    );
endinterface

// File: rtl/rr_request_agent.sv
// rtl/rr_request_agent.sv - per-channel job queue and transfer sequencer for a 4-way round-robin arbiter
//
// Purpose: counts pending jobs per channel, requests the arbiter, runs a
// HOLD_CYCLES-beat transfer per grant, then drops the owner's request for one
// cycle so the arbiter can rotate.
// Ports:
//   i_clk    - rising-edge clock
//   i_rst    - asynchronous active-low reset
//   agent_if - rr_request_agent_if.master (job_valid, grant in; req, bus_*,
//              job_done, grant_err, overflow out)
module rr_request_agent #(
    parameter int CNT_W       = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    rr_request_agent_if.master    agent_if
);
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_RELEASE} state_t;

    localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};
    localparam logic [3:0]       LAST_BEAT = 4'(HOLD_CYCLES - 1);

    state_t           r_state, w_state_nx;
    logic [1:0]       r_owner, w_owner_nx;
    logic [3:0]       r_beat, w_beat_nx;
    logic [3:0]       r_req, w_req_nx;
    logic [3:0]       r_ovf, w_ovf_nx;
    logic             r_gerr, w_gerr_nx;
    logic [CNT_W-1:0] r_pend [4];
    logic [CNT_W-1:0] w_pend_nx [4];

    logic [3:0]       w_owner_oh;
    logic [3:0]       w_done;
    logic [1:0]       w_grant_idx;
    logic             w_grant_onehot;
    logic             w_xfer;

    assign w_xfer         = (r_state == S_XFER);
    assign w_owner_oh     = 4'b0001 << r_owner;
    assign w_done         = (w_xfer && r_beat == LAST_BEAT) ? w_owner_oh : 4'b0000;
    assign w_grant_onehot = $onehot(agent_if.grant);

    always_comb begin
        w_grant_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (agent_if.grant[i]) w_grant_idx = 2'(i);
        end
    end

    // Next-state logic. grant_err is registered, so it appears the cycle
    // after the offending grant was sampled.
    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_beat_nx  = r_beat;
        w_gerr_nx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (agent_if.grant != 4'b0000) begin
                    if (w_grant_onehot && (agent_if.grant & r_req) != 4'b0000) begin
                        w_owner_nx = w_grant_idx;
                        w_beat_nx  = 4'd0;
                        w_state_nx = S_XFER;
                    end else begin
                        w_gerr_nx = 1'b1;
                    end
                end
            end
            S_XFER: begin
                // Grant only gets policed here; the transfer always runs to completion.
                if (agent_if.grant != w_owner_oh) w_gerr_nx = 1'b1;
                if (r_beat == LAST_BEAT) begin
                    w_beat_nx  = 4'd0;
                    w_state_nx = S_RELEASE;
                end else begin
                    w_beat_nx = r_beat + 4'd1;
                end
            end
            S_RELEASE: w_state_nx = S_IDLE;
            default:   w_state_nx = S_IDLE;
        endcase
    end

    // Pending counters: an add and a completion in the same cycle cancel.
    // A job arriving on a saturated counter is dropped and flagged.
    always_comb begin
        w_ovf_nx = r_ovf;
        w_req_nx = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_pend_nx[i] = r_pend[i];
            if (agent_if.job_valid[i] && !w_done[i]) begin
                if (r_pend[i] == PEND_MAX) w_ovf_nx[i] = 1'b1;
                else                       w_pend_nx[i] = r_pend[i] + CNT_W'(1);
            end else if (!agent_if.job_valid[i] && w_done[i]) begin
                w_pend_nx[i] = r_pend[i] - CNT_W'(1);
            end
            // Owner's request is masked during the release cycle so the arbiter rotates.
            w_req_nx[i] = (w_pend_nx[i] != '0) &&
                          !(w_state_nx == S_RELEASE && w_owner_nx == 2'(i));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_owner <= 2'd0;
            r_beat  <= 4'd0;
            r_req   <= 4'b0000;
            r_ovf   <= 4'b0000;
            r_gerr  <= 1'b0;
            for (int i = 0; i < 4; i++) r_pend[i] <= '0;
        end else begin
            r_state <= w_state_nx;
            r_owner <= w_owner_nx;
            r_beat  <= w_beat_nx;
            r_req   <= w_req_nx;
            r_ovf   <= w_ovf_nx;
            r_gerr  <= w_gerr_nx;
            for (int i = 0; i < 4; i++) r_pend[i] <= w_pend_nx[i];
        end
    end

    assign agent_if.req       = r_req;
    assign agent_if.bus_valid = w_xfer;
    assign agent_if.bus_ch    = w_xfer ? r_owner : 2'd0;
    assign agent_if.bus_beat  = w_xfer ? r_beat : 4'd0;
    assign agent_if.job_done  = w_done;
    assign agent_if.grant_err = r_gerr;
    assign agent_if.overflow  = r_ovf;
endmodule

// File: tb/tb_rr_request_agent.sv
// tb/tb_rr_request_agent.sv - self-checking bench for rr_request_agent
module tb_rr_request_agent;
    localparam int H    = 4;
    localparam int PMAX = 7;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    // Reference model: pending jobs per channel, sticky overflow, last completion.
    int         pend_m [4];
    logic [3:0] ovf_m;
    logic [3:0] last_jd;
    logic [3:0] jd_s;
    // Round-robin arbiter model: holds while the holder requests, else rotates.
    logic       held;
    int         last;

    rr_request_agent_if u_if ();

    rr_request_agent #(.CNT_W(3), .HOLD_CYCLES(H)) u_dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .agent_if (u_if)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] arb_grant(input logic [3:0] r);
        if (held && r[last]) return 4'b0001 << last;
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (r[c]) return 4'b0001 << c;
        end
        return 4'b0000;
    endfunction

    // One clock: drive inputs, let the edge happen, advance the model, return at negedge.
    task automatic cycle(input logic [3:0] jv, input logic [3:0] g);
        u_if.job_valid = jv;
        u_if.grant     = g;
        #1;
        jd_s = u_if.job_done;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (jv[i] && !jd_s[i]) begin
                if (pend_m[i] == PMAX) ovf_m[i] = 1'b1;
                else                   pend_m[i]++;
            end else if (!jv[i] && jd_s[i]) begin
                pend_m[i]--;
            end
        end
        last_jd = jd_s;
        held    = (g != 4'b0000);
        for (int i = 0; i < 4; i++) if (g[i]) last = i;
        @(negedge clk);
        u_if.job_valid = 4'b0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        u_if.job_valid = 4'b0000;
        u_if.grant     = 4'b0000;
        for (int i = 0; i < 4; i++) pend_m[i] = 0;
        ovf_m = 4'b0000; last_jd = 4'b0000; held = 1'b0; last = 3;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (u_if.req !== 4'b0000) begin errors++; $display("FAIL reset_req: got %b exp 0000", u_if.req); end
        checks++; if (u_if.bus_valid !== 1'b0) begin errors++; $display("FAIL reset_bus_valid: got %b exp 0", u_if.bus_valid); end
        checks++; if (u_if.overflow !== 4'b0000) begin errors++; $display("FAIL reset_overflow: got %b exp 0000", u_if.overflow); end
        checks++; if (u_if.job_done !== 4'b0000) begin errors++; $display("FAIL reset_job_done: got %b exp 0000", u_if.job_done); end
        checks++; if (u_if.grant_err !== 1'b0) begin errors++; $display("FAIL reset_grant_err: got %b exp 0", u_if.grant_err); end
    endtask

    task automatic test_single_job();
        do_reset();
        cycle(4'b0010, 4'b0000);
        checks++; if (u_if.req !== 4'b0010) begin errors++; $display("FAIL single_req: got %b exp 0010", u_if.req); end
        cycle(4'b0000, 4'b0010);
        for (int b = 0; b < H; b++) begin
            checks++; if (u_if.bus_valid !== 1'b1) begin errors++; $display("FAIL single_valid b%0d: got %b exp 1", b, u_if.bus_valid); end
            checks++; if (u_if.bus_ch !== 2'd1) begin errors++; $display("FAIL single_ch b%0d: got %0d exp 1", b, u_if.bus_ch); end
            checks++; if (u_if.bus_beat !== 4'(b)) begin errors++; $display("FAIL single_beat: got %0d exp %0d", u_if.bus_beat, b); end
            checks++; if (u_if.job_done !== ((b == H-1) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL single_done b%0d: got %b", b, u_if.job_done); end
            cycle(4'b0000, 4'b0010);
        end
        checks++; if (u_if.bus_valid !== 1'b0) begin errors++; $display("FAIL single_release_valid: got %b exp 0", u_if.bus_valid); end
        checks++; if (u_if.req !== 4'b0000) begin errors++; $display("FAIL single_release_req: got %b exp 0000", u_if.req); end
        checks++; if (u_if.grant_err !== 1'b0) begin errors++; $display("FAIL single_gerr: got %b exp 0", u_if.grant_err); end
        cycle(4'b0000, 4'b0000);
        cycle(4'b0000, 4'b0000);
        checks++; if (u_if.req !== 4'b0000) begin errors++; $display("FAIL single_req_after: got %b exp 0000", u_if.req); end
    endtask

    task automatic test_rotation();
        int order[$];
        int exp_order[4];
        int gerr_seen;
        exp_order = '{0, 3, 0, 3};
        gerr_seen = 0;
        do_reset();
        cycle(4'b1001, 4'b0000);
        cycle(4'b1001, 4'b0000);
        held = 1'b0; last = 3;
        for (int c = 0; c < 40; c++) begin
            if (u_if.bus_valid && u_if.bus_beat == 4'd0) order.push_back(int'(u_if.bus_ch));
            if (u_if.grant_err) gerr_seen++;
            if (last_jd != 4'b0000) begin
                checks++; if ((u_if.req & last_jd) !== 4'b0000) begin errors++; $display("FAIL rot_release_req: got %b owner %b", u_if.req, last_jd); end
            end
            cycle(4'b0000, arb_grant(u_if.req));
        end
        checks++; if (order.size() != 4) begin errors++; $display("FAIL rot_count: got %0d exp 4", order.size()); end
        for (int k = 0; k < 4 && k < order.size(); k++) begin
            checks++; if (order[k] != exp_order[k]) begin errors++; $display("FAIL rot_order[%0d]: got %0d exp %0d", k, order[k], exp_order[k]); end
        end
        checks++; if (u_if.req !== 4'b0000) begin errors++; $display("FAIL rot_req_end: got %b exp 0000", u_if.req); end
        checks++; if (gerr_seen != 0) begin errors++; $display("FAIL rot_gerr: got %0d exp 0", gerr_seen); end
    endtask

    task automatic test_saturation();
        int done2;
        done2 = 0;
        do_reset();
        for (int k = 0; k < PMAX + 1; k++) begin
            cycle(4'b0100, 4'b0000);
            if (k == PMAX - 1) begin
                checks++; if (u_if.overflow !== 4'b0000) begin errors++; $display("FAIL sat_ovf_at_max: got %b exp 0000", u_if.overflow); end
            end
        end
        checks++; if (u_if.overflow !== 4'b0100) begin errors++; $display("FAIL sat_ovf: got %b exp 0100", u_if.overflow); end
        checks++; if (u_if.req !== 4'b0100) begin errors++; $display("FAIL sat_req: got %b exp 0100", u_if.req); end
        held = 1'b0; last = 3;
        for (int c = 0; c < 60; c++) begin
            if (u_if.job_done[2]) done2++;
            cycle(4'b0000, arb_grant(u_if.req));
        end
        checks++; if (done2 != PMAX) begin errors++; $display("FAIL sat_drain: got %0d exp %0d", done2, PMAX); end
        checks++; if (u_if.overflow !== 4'b0100) begin errors++; $display("FAIL sat_sticky: got %b exp 0100", u_if.overflow); end
        checks++; if (u_if.req !== 4'b0000) begin errors++; $display("FAIL sat_req_end: got %b exp 0000", u_if.req); end
    endtask

    task automatic test_simultaneous();
        int done0;
        done0 = 0;
        do_reset();
        cycle(4'b0001, 4'b0000);
        cycle(4'b0000, 4'b0001);
        for (int b = 0; b < H; b++) begin
            if (b == H-1) begin
                checks++; if (u_if.job_done !== 4'b0001) begin errors++; $display("FAIL simul_done: got %b exp 0001", u_if.job_done); end
            end
            cycle((b == H-1) ? 4'b0001 : 4'b0000, 4'b0001);
        end
        checks++; if (u_if.req !== 4'b0000) begin errors++; $display("FAIL simul_release_req: got %b exp 0000", u_if.req); end
        cycle(4'b0000, 4'b0000);
        checks++; if (u_if.req !== 4'b0001) begin errors++; $display("FAIL simul_req_back: got %b exp 0001", u_if.req); end
        held = 1'b0; last = 3;
        for (int c = 0; c < 14; c++) begin
            if (u_if.job_done[0]) done0++;
            cycle(4'b0000, arb_grant(u_if.req));
        end
        checks++; if (done0 != 1) begin errors++; $display("FAIL simul_drain: got %0d exp 1", done0); end
    endtask

    task automatic test_illegal_grant();
        do_reset();
        cycle(4'b0110, 4'b0000);
        cycle(4'b0000, 4'b0110);
        checks++; if (u_if.grant_err !== 1'b1) begin errors++; $display("FAIL ill_multi_err: got %b exp 1", u_if.grant_err); end
        checks++; if (u_if.bus_valid !== 1'b0) begin errors++; $display("FAIL ill_multi_valid: got %b exp 0", u_if.bus_valid); end
        cycle(4'b0000, 4'b1000);
        checks++; if (u_if.grant_err !== 1'b1) begin errors++; $display("FAIL ill_noreq_err: got %b exp 1", u_if.grant_err); end
        checks++; if (u_if.bus_valid !== 1'b0) begin errors++; $display("FAIL ill_noreq_valid: got %b exp 0", u_if.bus_valid); end
        cycle(4'b0000, 4'b0000);
        checks++; if (u_if.grant_err !== 1'b0) begin errors++; $display("FAIL ill_err_clear: got %b exp 0", u_if.grant_err); end

        do_reset();
        cycle(4'b0001, 4'b0000);
        cycle(4'b0000, 4'b0001);
        for (int b = 0; b < H; b++) begin
            checks++; if (u_if.bus_valid !== 1'b1 || u_if.bus_ch !== 2'd0 || u_if.bus_beat !== 4'(b)) begin
                errors++; $display("FAIL ill_xfer b%0d: got v%b ch%0d beat%0d exp v1 ch0 beat%0d", b, u_if.bus_valid, u_if.bus_ch, u_if.bus_beat, b);
            end
            checks++; if (u_if.grant_err !== (b >= 3)) begin errors++; $display("FAIL ill_xfer_err b%0d: got %b exp %b", b, u_if.grant_err, b >= 3); end
            if (b == H-1) begin
                checks++; if (u_if.job_done !== 4'b0001) begin errors++; $display("FAIL ill_xfer_done: got %b exp 0001", u_if.job_done); end
            end
            cycle(4'b0000, (b < 2) ? 4'b0001 : 4'b0100);
        end
        checks++; if (u_if.grant_err !== 1'b1) begin errors++; $display("FAIL ill_release_err: got %b exp 1", u_if.grant_err); end
        cycle(4'b0000, 4'b0000);
        checks++; if (u_if.grant_err !== 1'b0) begin errors++; $display("FAIL ill_idle_err: got %b exp 0", u_if.grant_err); end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        done_seen = 0;
        do_reset();
        cycle(4'b0010, 4'b0000);
        cycle(4'b0010, 4'b0000);
        cycle(4'b0000, 4'b0010);
        cycle(4'b0000, 4'b0010);
        cycle(4'b0000, 4'b0010);
        checks++; if (u_if.bus_beat !== 4'd2) begin errors++; $display("FAIL rmid_beat: got %0d exp 2", u_if.bus_beat); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({u_if.req, u_if.bus_valid, u_if.bus_ch, u_if.bus_beat, u_if.job_done, u_if.grant_err, u_if.overflow} !== 20'd0) begin
            errors++; $display("FAIL rmid_async: got req%b v%b ch%0d beat%0d done%b err%b ovf%b exp all 0",
                               u_if.req, u_if.bus_valid, u_if.bus_ch, u_if.bus_beat, u_if.job_done, u_if.grant_err, u_if.overflow);
        end
        for (int i = 0; i < 4; i++) pend_m[i] = 0;
        ovf_m = 4'b0000; last_jd = 4'b0000;
        u_if.grant = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (u_if.job_done != 4'b0000) done_seen++;
            checks++; if (u_if.req !== 4'b0000) begin errors++; $display("FAIL rmid_req c%0d: got %b exp 0000", c, u_if.req); end
            cycle(4'b0000, 4'b0000);
        end
        checks++; if (done_seen != 0) begin errors++; $display("FAIL rmid_done: got %0d exp 0", done_seen); end
    endtask

    task automatic test_random();
        logic [3:0] jv, exp_req, exp_done;
        do_reset();
        held = 1'b0; last = 3;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < 4; i++) exp_req[i] = (pend_m[i] != 0) && !last_jd[i];
            checks++; if (u_if.req !== exp_req) begin errors++; $display("FAIL rnd_req c%0d: got %b exp %b", c, u_if.req, exp_req); end
            checks++; if (u_if.overflow !== ovf_m) begin errors++; $display("FAIL rnd_ovf c%0d: got %b exp %b", c, u_if.overflow, ovf_m); end
            checks++; if (u_if.grant_err !== 1'b0) begin errors++; $display("FAIL rnd_gerr c%0d: got %b exp 0", c, u_if.grant_err); end
            exp_done = (u_if.bus_valid && u_if.bus_beat == 4'(H-1)) ? (4'b0001 << u_if.bus_ch) : 4'b0000;
            checks++; if (u_if.job_done !== exp_done) begin errors++; $display("FAIL rnd_done c%0d: got %b exp %b", c, u_if.job_done, exp_done); end
            if (u_if.bus_valid && u_if.bus_beat == 4'd0) begin
                checks++; if (pend_m[u_if.bus_ch] == 0) begin errors++; $display("FAIL rnd_start c%0d: got ch%0d with pend 0 exp pend>0", c, u_if.bus_ch); end
            end
            jv = 4'b0000;
            if (c < 300) for (int i = 0; i < 4; i++) jv[i] = ($urandom_range(0, 3) == 0);
            cycle(jv, arb_grant(u_if.req));
        end
        checks++; if (u_if.req !== 4'b0000) begin errors++; $display("FAIL rnd_drain_req: got %b exp 0000", u_if.req); end
    endtask

    initial begin
        rst = 1'b0;
        u_if.job_valid = 4'b0000;
        u_if.grant     = 4'b0000;
        for (int i = 0; i < 4; i++) pend_m[i] = 0;
        ovf_m = 4'b0000; last_jd = 4'b0000; jd_s = 4'b0000; held = 1'b0; last = 3;
        test_reset();
        test_single_job();
        test_rotation();
        test_saturation();
        test_simultaneous();
        test_illegal_grant();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
